// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst scheduler: state encoding and default widths.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;
  localparam int unsigned SDRAM_LEN_W  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-port burst address pointer: load edge detect, FIFO clear pulse and wrapping
// advance inside the [minaddr, maxaddr] window.
module sdram_addr_gen #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_busy,
  input  logic              i_done,
  input  logic [ADDR_W-1:0] i_minaddr,
  input  logic [ADDR_W-1:0] i_maxaddr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_clr,
  output logic              o_hold
);

  logic              r_load_d;
  logic              r_clr;
  logic              r_skip;
  logic [ADDR_W-1:0] r_addr;

  logic              w_edge;
  logic [ADDR_W:0]   w_len_ext;
  logic [ADDR_W:0]   w_next;
  logic [ADDR_W:0]   w_end;
  logic [ADDR_W:0]   w_limit;
  logic [ADDR_W-1:0] w_wrap;

  always_comb begin
    w_edge    = i_load && !r_load_d;
    w_len_ext = {{(ADDR_W + 1 - LEN_W){1'b0}}, i_len};
    w_next    = {1'b0, r_addr} + w_len_ext;
    w_end     = w_next + w_len_ext;
    w_limit   = {1'b0, i_maxaddr} + (ADDR_W + 1)'(1);
    w_wrap    = (w_end > w_limit) ? i_minaddr : w_next[ADDR_W-1:0];
  end

  // A load during a burst arms r_skip so the pending done keeps the pointer at minaddr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_d <= 1'b0;
      r_clr    <= 1'b0;
      r_skip   <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_load_d <= i_load;
      r_clr    <= w_edge;
      if (w_edge) begin
        r_addr <= i_minaddr;
        r_skip <= i_busy && !i_done;
      end else if (i_done) begin
        if (!r_skip) r_addr <= w_wrap;
        r_skip <= 1'b0;
      end
    end
  end

  // Hold off grants on the edge cycle and the clear cycle so the FIFO level has settled.
  assign o_hold = w_edge || r_clr;
  assign o_addr = r_addr;
  assign o_clr  = r_clr;

endmodule

// File: rtl/sdram_rw_sched.sv
// Write/read burst scheduler between the user FIFOs and the SDRAM controller.
// Optional: define SDRAM_RR_ARB_EN for round-robin arbitration (default: write priority).
module sdram_rw_sched
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = SDRAM_ADDR_W,
  parameter int unsigned LEN_W  = SDRAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              sdram_read_valid,
  input  logic [ADDR_W-1:0] wr_minaddr,
  input  logic [ADDR_W-1:0] wr_maxaddr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] rd_minaddr,
  input  logic [ADDR_W-1:0] rd_maxaddr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              rd_load,
  input  logic [LEN_W:0]    wrf_usedw,
  input  logic [LEN_W:0]    rdf_usedw,
  output logic              wrf_clr,
  output logic              rdf_clr,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [LEN_W-1:0]  sdram_wr_burst,
  input  logic              sdram_wr_done,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LEN_W-1:0]  sdram_rd_burst,
  input  logic              sdram_rd_done
);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_wr_burst;
  logic [LEN_W-1:0]  r_rd_burst;

  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic              w_wr_hold;
  logic              w_rd_hold;
  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_wr_pref;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic              w_wr_done;
  logic              w_rd_done;

  always_comb begin
    w_wr_elig  = sdram_init_done && (wr_len != '0) &&
                 (wrf_usedw >= {1'b0, wr_len}) && !w_wr_hold;
    w_rd_elig  = sdram_init_done && sdram_read_valid && (rd_len != '0) &&
                 (rdf_usedw < {1'b0, rd_len}) && !w_rd_hold;
    w_grant_wr = (r_state == IDLE) && w_wr_elig && (!w_rd_elig || w_wr_pref);
    w_grant_rd = (r_state == IDLE) && w_rd_elig && !w_grant_wr;
    w_wr_done  = sdram_wr_done && (r_state == WR_BUSY);
    w_rd_done  = sdram_rd_done && (r_state == RD_BUSY);
  end

`ifdef SDRAM_RR_ARB_EN
  logic r_last_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last_rd <= 1'b1;
    else if (w_grant_wr) r_last_rd <= 1'b0;
    else if (w_grant_rd) r_last_rd <= 1'b1;
  end

  assign w_wr_pref = r_last_rd;
`else
  assign w_wr_pref = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_wr)      w_state_nxt = WR_BUSY;
        else if (w_grant_rd) w_state_nxt = RD_BUSY;
      end
      WR_BUSY: if (sdram_wr_done) w_state_nxt = IDLE;
      RD_BUSY: if (sdram_rd_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram_wr_req = (r_state == WR_BUSY);
    sdram_rd_req = (r_state == RD_BUSY);
  end

  // Burst address/length are captured at grant so a mid-burst load cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr  <= '0;
      r_wr_burst <= '0;
      r_rd_addr  <= '0;
      r_rd_burst <= '0;
    end else begin
      if (w_grant_wr) begin
        r_wr_addr  <= w_wr_ptr;
        r_wr_burst <= wr_len;
      end
      if (w_grant_rd) begin
        r_rd_addr  <= w_rd_ptr;
        r_rd_burst <= rd_len;
      end
    end
  end

  assign sdram_wr_addr  = r_wr_addr;
  assign sdram_wr_burst = r_wr_burst;
  assign sdram_rd_addr  = r_rd_addr;
  assign sdram_rd_burst = r_rd_burst;

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_wr_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (wr_load),
    .i_busy    (r_state == WR_BUSY),
    .i_done    (w_wr_done),
    .i_minaddr (wr_minaddr),
    .i_maxaddr (wr_maxaddr),
    .i_len     (wr_len),
    .o_addr    (w_wr_ptr),
    .o_clr     (wrf_clr),
    .o_hold    (w_wr_hold)
  );

  sdram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_rd_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (rd_load),
    .i_busy    (r_state == RD_BUSY),
    .i_done    (w_rd_done),
    .i_minaddr (rd_minaddr),
    .i_maxaddr (rd_maxaddr),
    .i_len     (rd_len),
    .o_addr    (w_rd_ptr),
    .o_clr     (rdf_clr),
    .o_hold    (w_rd_hold)
  );

endmodule

// File: tb/tb_sdram_rw_sched.sv
// Directed self-checking bench for sdram_rw_sched; expectations follow SDRAM_RR_ARB_EN.
module tb_sdram_rw_sched;

  localparam int unsigned AW = 24;
  localparam int unsigned LW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sdram_init_done;
  logic          sdram_read_valid;
  logic [AW-1:0] wr_minaddr, wr_maxaddr, rd_minaddr, rd_maxaddr;
  logic [LW-1:0] wr_len, rd_len;
  logic          wr_load, rd_load;
  logic [LW:0]   wrf_usedw, rdf_usedw;
  logic          wrf_clr, rdf_clr;
  logic          sdram_wr_req, sdram_rd_req;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [LW-1:0] sdram_wr_burst, sdram_rd_burst;
  logic          sdram_wr_done, sdram_rd_done;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  sdram_rw_sched #(
    .ADDR_W (AW),
    .LEN_W  (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sdram_init_done  (sdram_init_done),
    .sdram_read_valid (sdram_read_valid),
    .wr_minaddr       (wr_minaddr),
    .wr_maxaddr       (wr_maxaddr),
    .wr_len           (wr_len),
    .wr_load          (wr_load),
    .rd_minaddr       (rd_minaddr),
    .rd_maxaddr       (rd_maxaddr),
    .rd_len           (rd_len),
    .rd_load          (rd_load),
    .wrf_usedw        (wrf_usedw),
    .rdf_usedw        (rdf_usedw),
    .wrf_clr          (wrf_clr),
    .rdf_clr          (rdf_clr),
    .sdram_wr_req     (sdram_wr_req),
    .sdram_wr_addr    (sdram_wr_addr),
    .sdram_wr_burst   (sdram_wr_burst),
    .sdram_wr_done    (sdram_wr_done),
    .sdram_rd_req     (sdram_rd_req),
    .sdram_rd_addr    (sdram_rd_addr),
    .sdram_rd_burst   (sdram_rd_burst),
    .sdram_rd_done    (sdram_rd_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse the done of one side, check both requests drop, then let IDLE sample once.
  task automatic finish_burst(input logic is_wr);
    if (is_wr) sdram_wr_done = 1'b1;
    else       sdram_rd_done = 1'b1;
    step(1);
    sdram_wr_done = 1'b0;
    sdram_rd_done = 1'b0;
    check("gap_wr_req", 32'(sdram_wr_req), 32'd0);
    check("gap_rd_req", 32'(sdram_rd_req), 32'd0);
    step(1);
  endtask

  logic [AW-1:0] wrap_exp [4];
  logic          cont_wr  [3];

  initial begin
    wrap_exp = '{24'h000100, 24'h000200, 24'h000300, 24'h000000};
`ifdef SDRAM_RR_ARB_EN
    cont_wr  = '{1'b1, 1'b0, 1'b1};
`else
    cont_wr  = '{1'b1, 1'b1, 1'b1};
`endif

    rst_n            = 1'b0;
    sdram_init_done  = 1'b0;
    sdram_read_valid = 1'b0;
    wr_minaddr       = 24'h000000;
    wr_maxaddr       = 24'h0003FF;
    wr_len           = 10'd256;
    wr_load          = 1'b0;
    rd_minaddr       = 24'h001000;
    rd_maxaddr       = 24'h0013FF;
    rd_len           = 10'd256;
    rd_load          = 1'b0;
    wrf_usedw        = 11'd512;
    rdf_usedw        = 11'd512;
    sdram_wr_done    = 1'b0;
    sdram_rd_done    = 1'b0;
    step(3);

    check("rst_wr_req",   32'(sdram_wr_req),   32'd0);
    check("rst_rd_req",   32'(sdram_rd_req),   32'd0);
    check("rst_wr_addr",  32'(sdram_wr_addr),  32'd0);
    check("rst_rd_addr",  32'(sdram_rd_addr),  32'd0);
    check("rst_wr_burst", 32'(sdram_wr_burst), 32'd0);
    check("rst_wrf_clr",  32'(wrf_clr),        32'd0);
    check("rst_rdf_clr",  32'(rdf_clr),        32'd0);

    rst_n = 1'b1;
    step(1);
    rd_load = 1'b1;
    step(1);
    check("rd_load_clr", 32'(rdf_clr), 32'd1);
    rd_load = 1'b0;
    step(1);
    check("rd_clr_once", 32'(rdf_clr), 32'd0);
    step(2);
    check("init_gate", 32'(sdram_wr_req), 32'd0);

    sdram_init_done = 1'b1;
    step(1);
    check("first_wr_req",   32'(sdram_wr_req),   32'd1);
    check("first_wr_addr",  32'(sdram_wr_addr),  32'h000000);
    check("first_wr_burst", 32'(sdram_wr_burst), 32'd256);
    step(3);
    check("wr_req_held", 32'(sdram_wr_req), 32'd1);

    sdram_rd_done = 1'b1;
    step(1);
    sdram_rd_done = 1'b0;
    check("foreign_done", 32'(sdram_wr_req), 32'd1);

    for (int i = 0; i < 4; i++) begin
      finish_burst(1'b1);
      check("wrap_req",  32'(sdram_wr_req),  32'd1);
      check("wrap_addr", 32'(sdram_wr_addr), 32'(wrap_exp[i]));
    end

    finish_burst(1'b1);
    check("pre_load_addr", 32'(sdram_wr_addr), 32'h000100);
    wr_load = 1'b1;
    step(1);
    check("ld_clr",       32'(wrf_clr),       32'd1);
    check("ld_req_held",  32'(sdram_wr_req),  32'd1);
    check("ld_addr_held", 32'(sdram_wr_addr), 32'h000100);
    wr_load = 1'b0;
    step(1);
    check("ld_clr_once", 32'(wrf_clr), 32'd0);
    finish_burst(1'b1);
    check("ld_next_req",  32'(sdram_wr_req),  32'd1);
    check("ld_next_addr", 32'(sdram_wr_addr), 32'h000000);

    finish_burst(1'b1);
    check("pre_ldd_addr", 32'(sdram_wr_addr), 32'h000100);
    wr_load       = 1'b1;
    sdram_wr_done = 1'b1;
    step(1);
    wr_load       = 1'b0;
    sdram_wr_done = 1'b0;
    check("ldd_req_low", 32'(sdram_wr_req), 32'd0);
    check("ldd_clr",     32'(wrf_clr),      32'd1);
    step(1);
    check("ldd_blocked", 32'(sdram_wr_req), 32'd0);
    step(1);
    check("ldd_next_req",  32'(sdram_wr_req),  32'd1);
    check("ldd_next_addr", 32'(sdram_wr_addr), 32'h000000);

    wrf_usedw = 11'd0;
    rdf_usedw = 11'd0;
    finish_burst(1'b1);
    step(2);
    check("rd_gate_rd", 32'(sdram_rd_req), 32'd0);
    check("rd_gate_wr", 32'(sdram_wr_req), 32'd0);
    sdram_read_valid = 1'b1;
    step(1);
    check("rd_req",   32'(sdram_rd_req),   32'd1);
    check("rd_addr",  32'(sdram_rd_addr),  32'h001000);
    check("rd_burst", 32'(sdram_rd_burst), 32'd256);

    wrf_usedw = 11'd512;
    finish_burst(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("cont_wr_req", 32'(sdram_wr_req), 32'(cont_wr[i]));
      check("cont_rd_req", 32'(sdram_rd_req), 32'(!cont_wr[i]));
      finish_burst(cont_wr[i]);
    end

    wrf_usedw = 11'd0;
    if (sdram_wr_req) finish_burst(1'b1);
    check("pre_rst_rd_req", 32'(sdram_rd_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rd_req",   32'(sdram_rd_req),   32'd0);
    check("arst_wr_req",   32'(sdram_wr_req),   32'd0);
    check("arst_rd_addr",  32'(sdram_rd_addr),  32'd0);
    check("arst_wr_addr",  32'(sdram_wr_addr),  32'd0);
    check("arst_rd_burst", 32'(sdram_rd_burst), 32'd0);
    step(2);
    check("arst_hold_rd_req", 32'(sdram_rd_req), 32'd0);
    rst_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
